// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle for the multi-cycle MIPS control unit.
// IllegalOp exists only when ILLEGAL_TRAP_EN is defined.
interface multicycle_control_if #(
   parameter int ALUOP_WIDTH = 4,
   parameter int CNT_WIDTH   = 32
);
   logic [5:0]             OP;
   logic                   Zero;
   logic                   MemReady;
   logic                   PCWrite;
   logic                   PCWriteCond;
   logic                   IorD;
   logic                   MemRead;
   logic                   MemWrite;
   logic                   IRWrite;
   logic                   MemtoReg;
   logic [1:0]             PCSource;
   logic                   ALUSrcA;
   logic [1:0]             ALUSrcB;
   logic [ALUOP_WIDTH-1:0] ALUOp;
   logic                   RegWrite;
   logic [1:0]             RegDst;
   logic                   MemTimeout;
   logic [CNT_WIDTH-1:0]   InstrCount;
   logic [3:0]             State;
`ifdef ILLEGAL_TRAP_EN
   logic                   IllegalOp;
`endif

   modport master (
      input  OP, Zero, MemReady,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             PCSource, ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDst,
             MemTimeout, InstrCount, State
`ifdef ILLEGAL_TRAP_EN
      , output IllegalOp
`endif
   );

   modport slave (
      output OP, Zero, MemReady,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             PCSource, ALUSrcA, ALUSrcB, ALUOp, RegWrite, RegDst,
             MemTimeout, InstrCount, State
`ifdef ILLEGAL_TRAP_EN
      , input IllegalOp
`endif
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory-ready wait, optional access timeout and retire counter.
// Define ILLEGAL_TRAP_EN to send unknown opcodes to a sticky TRAP state with IllegalOp.
module multicycle_control #(
   parameter int ALUOP_WIDTH = 4,
   parameter int CNT_WIDTH   = 32,
   parameter int MEM_TIMEOUT = 0
) (
   input logic                  clk,
   input logic                  reset,
   multicycle_control_if.master ctl
);
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      EXEC_I   = 4'd3,
      ALU_WB   = 4'd4,
      MEM_ADDR = 4'd5,
      MEM_RD   = 4'd6,
      MEM_WB   = 4'd7,
      MEM_WR   = 4'd8,
      BRANCH   = 4'd9,
      JUMP     = 4'd10,
      TRAP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [3:0] ALU_ADD  = 4'b0001;
   localparam logic [3:0] ALU_SUB  = 4'b0011;
   localparam logic [3:0] ALU_ADDI = 4'b0100;
   localparam logic [3:0] ALU_ORI  = 4'b0101;
   localparam logic [3:0] ALU_LUI  = 4'b0110;
   localparam logic [3:0] ALU_FUNC = 4'b1111;

   state_t               state;
   state_t               state_next;
   logic [5:0]           op_q;
   logic [CNT_WIDTH-1:0] instr_count;
   logic                 mem_timeout;
   logic [31:0]          wait_cnt;
   logic                 mem_state;
   logic                 timeout_hit;
   logic                 retire;

   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       memto_reg, alu_src_a, reg_write;
   logic [1:0] pc_source, alu_src_b, reg_dst;
   logic [3:0] alu_code;
`ifdef ILLEGAL_TRAP_EN
   logic       illegal_op;
`endif

   assign mem_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

   // The access is abandoned on the edge where the wait counter would reach MEM_TIMEOUT.
   assign timeout_hit = (MEM_TIMEOUT > 0) && mem_state && !ctl.MemReady &&
                        (wait_cnt == 32'(MEM_TIMEOUT - 1));

   always_comb begin
      state_next = state;
      retire     = 1'b0;
      case (state)
         FETCH: begin
            if (timeout_hit)       state_next = FETCH;
            else if (ctl.MemReady) state_next = DECODE;
         end
         DECODE: begin
            case (ctl.OP)
               OP_RTYPE:                state_next = EXEC_R;
               OP_ADDI, OP_ORI, OP_LUI: state_next = EXEC_I;
               OP_LW, OP_SW:            state_next = MEM_ADDR;
               OP_BEQ, OP_BNE:          state_next = BRANCH;
               OP_J, OP_JAL:            state_next = JUMP;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  state_next = TRAP;
`else
                  state_next = FETCH;
                  retire     = 1'b1;
`endif
               end
            endcase
         end
         EXEC_R, EXEC_I: state_next = ALU_WB;
         MEM_ADDR:       state_next = (op_q == OP_SW) ? MEM_WR : MEM_RD;
         MEM_RD: begin
            if (timeout_hit)       state_next = FETCH;
            else if (ctl.MemReady) state_next = MEM_WB;
         end
         MEM_WR: begin
            if (timeout_hit) begin
               state_next = FETCH;
            end else if (ctl.MemReady) begin
               state_next = FETCH;
               retire     = 1'b1;
            end
         end
         ALU_WB, MEM_WB, BRANCH, JUMP: begin
            state_next = FETCH;
            retire     = 1'b1;
         end
         TRAP:    state_next = TRAP;
         default: state_next = FETCH;
      endcase
   end

   // Outputs are forced low while reset is held so no strobe leaks out of the FETCH reset state.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      memto_reg     = 1'b0;
      alu_src_a     = 1'b0;
      reg_write     = 1'b0;
      pc_source     = 2'b00;
      alu_src_b     = 2'b00;
      reg_dst       = 2'b00;
      alu_code      = 4'b0000;
`ifdef ILLEGAL_TRAP_EN
      illegal_op    = 1'b0;
`endif
      if (reset) begin
         case (state)
            FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               alu_code  = ALU_ADD;
               ir_write  = ctl.MemReady;
               pc_write  = ctl.MemReady;
            end
            DECODE: begin
               alu_src_b = 2'b11;
               alu_code  = ALU_ADD;
            end
            EXEC_R: begin
               alu_src_a = 1'b1;
               alu_code  = ALU_FUNC;
            end
            EXEC_I: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               case (op_q)
                  OP_ADDI: alu_code = ALU_ADDI;
                  OP_ORI:  alu_code = ALU_ORI;
                  OP_LUI:  alu_code = ALU_LUI;
                  default: alu_code = 4'b0000;
               endcase
            end
            ALU_WB: begin
               reg_write = 1'b1;
               reg_dst   = (op_q == OP_RTYPE) ? 2'b01 : 2'b00;
            end
            MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu_code  = ALU_ADD;
            end
            MEM_RD: begin
               iord     = 1'b1;
               mem_read = 1'b1;
            end
            MEM_WB: begin
               reg_write = 1'b1;
               memto_reg = 1'b1;
            end
            MEM_WR: begin
               iord      = 1'b1;
               mem_write = 1'b1;
            end
            BRANCH: begin
               alu_src_a     = 1'b1;
               alu_code      = ALU_SUB;
               pc_source     = 2'b01;
               pc_write_cond = ((op_q == OP_BEQ) && ctl.Zero) ||
                               ((op_q == OP_BNE) && !ctl.Zero);
            end
            JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'b10;
               if (op_q == OP_JAL) begin
                  reg_write = 1'b1;
                  reg_dst   = 2'b10;
               end
            end
            TRAP: begin
`ifdef ILLEGAL_TRAP_EN
               illegal_op = 1'b1;
`endif
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= FETCH;
         op_q        <= 6'h00;
         instr_count <= '0;
         mem_timeout <= 1'b0;
         wait_cnt    <= 32'd0;
      end else begin
         state <= state_next;
         if (state == DECODE) op_q <= ctl.OP;
         if (retire) instr_count <= instr_count + CNT_WIDTH'(1);
         if (timeout_hit) mem_timeout <= 1'b1;
         // Clearing on every transition (and on a timeout re-entry) covers entry to each memory state.
         if ((state_next != state) || timeout_hit) wait_cnt <= 32'd0;
         else if (mem_state && !ctl.MemReady) wait_cnt <= wait_cnt + 32'd1;
      end
   end

   assign ctl.PCWrite     = pc_write;
   assign ctl.PCWriteCond = pc_write_cond;
   assign ctl.IorD        = iord;
   assign ctl.MemRead     = mem_read;
   assign ctl.MemWrite    = mem_write;
   assign ctl.IRWrite     = ir_write;
   assign ctl.MemtoReg    = memto_reg;
   assign ctl.PCSource    = pc_source;
   assign ctl.ALUSrcA     = alu_src_a;
   assign ctl.ALUSrcB     = alu_src_b;
   assign ctl.ALUOp       = ALUOP_WIDTH'(alu_code);
   assign ctl.RegWrite    = reg_write;
   assign ctl.RegDst      = reg_dst;
   assign ctl.MemTimeout  = mem_timeout;
   assign ctl.InstrCount  = instr_count;
   assign ctl.State       = state;
`ifdef ILLEGAL_TRAP_EN
   assign ctl.IllegalOp   = illegal_op;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction table with a scoreboard queue, plus timeout, reset and trap sequences.
module tb_multicycle_control;
   localparam int W = 63;
   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_ALU_WB = 4'd4;
   localparam logic [3:0] S_MEM_RD = 4'd6;
   localparam logic [3:0] S_MEM_WB = 4'd7;
   localparam logic [3:0] S_MEM_WR = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_JUMP   = 4'd10;
   localparam logic [3:0] S_TRAP   = 4'd11;

   typedef struct {
      logic [5:0]  op;
      logic        zero;
      int          waits;
      int          cycles;
      logic [3:0]  last_st;
      logic [11:0] last_ctl;
      logic [6:0]  c3;
      logic        retire;
   } vec_t;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_miss;
   int   n_tab;
   logic [31:0] exp_cnt;
   vec_t vecs[16];
   logic [W-1:0] exp_q[$];

   multicycle_control_if #(.ALUOP_WIDTH(4), .CNT_WIDTH(32)) bus ();

   multicycle_control #(.ALUOP_WIDTH(4), .CNT_WIDTH(32), .MEM_TIMEOUT(5)) dut (
      .clk   (clk),
      .reset (reset),
      .ctl   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] mk_ctl(input logic pw, pwc, iord, mr, mw, ir, mtr, rw,
                                          input logic [1:0] ps, rd);
      return {pw, pwc, iord, mr, mw, ir, mtr, rw, ps, rd};
   endfunction

   function automatic logic [11:0] snap_ctl();
      return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
              bus.MemtoReg, bus.RegWrite, bus.PCSource, bus.RegDst};
   endfunction

   task automatic add_vec(input logic [5:0] op, input logic zero, input int waits, input int cycles,
                          input logic [3:0] last_st, input logic [11:0] last_ctl,
                          input logic [6:0] c3, input logic retire);
      vecs[n_tab] = '{op, zero, waits, cycles, last_st, last_ctl, c3, retire};
      n_tab++;
   endtask

   // Starts and ends at a falling edge with the FSM in FETCH.
   task automatic run_instr(input logic [5:0] op, input logic zero, input int waits,
                            output int n, output logic [3:0] lst, output logic [11:0] lctl,
                            output logic [6:0] c3);
      int seen;
      seen = 0; n = 0; lst = '0; lctl = '0; c3 = '0;
      bus.OP = op;
      bus.Zero = zero;
      bus.MemReady = 1'b1;
      for (int k = 0; k < 40; k++) begin
         n++;
         if (bus.State == S_MEM_RD || bus.State == S_MEM_WR) begin
            bus.MemReady = (seen >= waits);
            seen++;
         end else begin
            bus.MemReady = 1'b1;
         end
         #1;
         if (n == 3) c3 = {bus.ALUOp[3:0], bus.ALUSrcB, bus.ALUSrcA};
         lst = bus.State;
         lctl = snap_ctl();
         @(negedge clk);
         if (bus.State == S_FETCH) break;
      end
      if (n < 3) c3 = {bus.ALUOp[3:0], bus.ALUSrcB, bus.ALUSrcA};
   endtask

   task automatic wait_state(input logic [3:0] s, input string name);
      int k;
      k = 0;
      while (bus.State !== s && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk(name, 64'(bus.State), 64'(s));
   endtask

   initial begin
      int n;
      int wr_cycles;
      int bad;
      logic [3:0]  lst;
      logic [11:0] lctl;
      logic [6:0]  c3;
      logic [W-1:0] e;

      n_vec = 0; n_miss = 0; n_tab = 0; exp_cnt = 32'd0;
      add_vec(6'h00, 1'b0, 0, 4, S_ALU_WB, mk_ctl(0,0,0,0,0,0,0,1,2'b00,2'b01), {4'b1111, 2'b00, 1'b1}, 1'b1);
      add_vec(6'h08, 1'b0, 0, 4, S_ALU_WB, mk_ctl(0,0,0,0,0,0,0,1,2'b00,2'b00), {4'b0100, 2'b10, 1'b1}, 1'b1);
      add_vec(6'h0d, 1'b1, 0, 4, S_ALU_WB, mk_ctl(0,0,0,0,0,0,0,1,2'b00,2'b00), {4'b0101, 2'b10, 1'b1}, 1'b1);
      add_vec(6'h0f, 1'b0, 0, 4, S_ALU_WB, mk_ctl(0,0,0,0,0,0,0,1,2'b00,2'b00), {4'b0110, 2'b10, 1'b1}, 1'b1);
      add_vec(6'h23, 1'b0, 3, 8, S_MEM_WB, mk_ctl(0,0,0,0,0,0,1,1,2'b00,2'b00), {4'b0001, 2'b10, 1'b1}, 1'b1);
      add_vec(6'h23, 1'b0, 0, 5, S_MEM_WB, mk_ctl(0,0,0,0,0,0,1,1,2'b00,2'b00), {4'b0001, 2'b10, 1'b1}, 1'b1);
      add_vec(6'h2b, 1'b0, 2, 6, S_MEM_WR, mk_ctl(0,0,1,0,1,0,0,0,2'b00,2'b00), {4'b0001, 2'b10, 1'b1}, 1'b1);
      add_vec(6'h04, 1'b1, 0, 3, S_BRANCH, mk_ctl(0,1,0,0,0,0,0,0,2'b01,2'b00), {4'b0011, 2'b00, 1'b1}, 1'b1);
      add_vec(6'h04, 1'b0, 0, 3, S_BRANCH, mk_ctl(0,0,0,0,0,0,0,0,2'b01,2'b00), {4'b0011, 2'b00, 1'b1}, 1'b1);
      add_vec(6'h05, 1'b1, 0, 3, S_BRANCH, mk_ctl(0,0,0,0,0,0,0,0,2'b01,2'b00), {4'b0011, 2'b00, 1'b1}, 1'b1);
      add_vec(6'h05, 1'b0, 0, 3, S_BRANCH, mk_ctl(0,1,0,0,0,0,0,0,2'b01,2'b00), {4'b0011, 2'b00, 1'b1}, 1'b1);
      add_vec(6'h02, 1'b0, 0, 3, S_JUMP,   mk_ctl(1,0,0,0,0,0,0,0,2'b10,2'b00), {4'b0000, 2'b00, 1'b0}, 1'b1);
      add_vec(6'h03, 1'b0, 0, 3, S_JUMP,   mk_ctl(1,0,0,0,0,0,0,1,2'b10,2'b10), {4'b0000, 2'b00, 1'b0}, 1'b1);
`ifndef ILLEGAL_TRAP_EN
      add_vec(6'h3f, 1'b0, 0, 2, S_DECODE, mk_ctl(0,0,0,0,0,0,0,0,2'b00,2'b00), {4'b0001, 2'b01, 1'b0}, 1'b1);
`endif

      // Reset state
      reset = 1'b0;
      bus.OP = 6'h00;
      bus.Zero = 1'b1;
      bus.MemReady = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_outputs", 64'({bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                                bus.IRWrite, bus.MemtoReg, bus.PCSource, bus.ALUSrcA, bus.ALUSrcB,
                                bus.ALUOp, bus.RegWrite, bus.RegDst}), 64'd0);
      chk("reset_state", 64'(bus.State), 64'(S_FETCH));
      chk("reset_count", 64'(bus.InstrCount), 64'd0);
      chk("reset_timeout", 64'(bus.MemTimeout), 64'd0);

      // FETCH holds while memory is not ready, then loads IR and PC together
      bus.MemReady = 1'b0;
      reset = 1'b1;
      #1;
      chk("fetch_wait_ctl", 64'(snap_ctl()), 64'(mk_ctl(0,0,0,1,0,0,0,0,2'b00,2'b00)));
      repeat (2) @(negedge clk);
      chk("fetch_hold_state", 64'(bus.State), 64'(S_FETCH));
      bus.MemReady = 1'b1;
      #1;
      chk("fetch_ready_ctl", 64'(snap_ctl()), 64'(mk_ctl(1,0,0,1,0,1,0,0,2'b00,2'b00)));
      chk("fetch_alu", 64'({bus.ALUOp, bus.ALUSrcB, bus.ALUSrcA}), 64'({4'b0001, 2'b01, 1'b0}));

      // Instruction table through the scoreboard
      for (int i = 0; i < n_tab; i++) begin
         exp_cnt = exp_cnt + 32'(vecs[i].retire);
         exp_q.push_back({8'(vecs[i].cycles), vecs[i].last_st, vecs[i].last_ctl, vecs[i].c3, exp_cnt});
         run_instr(vecs[i].op, vecs[i].zero, vecs[i].waits, n, lst, lctl, c3);
         e = exp_q.pop_front();
         chk($sformatf("v%0d_cycles", i), 64'(n), 64'(e[62:55]));
         chk($sformatf("v%0d_last_state", i), 64'(lst), 64'(e[54:51]));
         chk($sformatf("v%0d_last_ctl", i), 64'(lctl), 64'(e[50:39]));
         chk($sformatf("v%0d_cycle3_alu", i), 64'(c3), 64'(e[38:32]));
         chk($sformatf("v%0d_count", i), 64'(bus.InstrCount), 64'(e[31:0]));
      end
      chk("no_timeout_yet", 64'(bus.MemTimeout), 64'd0);

      // SW with memory stuck: abandoned after five write cycles, not counted
      bus.OP = 6'h2b;
      bus.MemReady = 1'b1;
      wait_state(S_MEM_WR, "to_mem_wr_a");
      bus.MemReady = 1'b0;
      wr_cycles = 0;
      for (int k = 0; k < 20 && bus.State == S_MEM_WR; k++) begin
         if (bus.MemWrite) wr_cycles++;
         @(negedge clk);
      end
      chk("timeout_wr_cycles", 64'(wr_cycles), 64'd5);
      chk("timeout_state", 64'(bus.State), 64'(S_FETCH));
      chk("timeout_flag", 64'(bus.MemTimeout), 64'd1);
      chk("timeout_count", 64'(bus.InstrCount), 64'(exp_cnt));
      bus.MemReady = 1'b1;

      // Reset pulled in the middle of a write
      @(negedge clk);
      wait_state(S_MEM_WR, "to_mem_wr_b");
      bus.MemReady = 1'b0;
      @(negedge clk);
      chk("mid_write_strobe", 64'(bus.MemWrite), 64'd1);
      reset = 1'b0;
      #1;
      chk("rst_write_drop", 64'(bus.MemWrite), 64'd0);
      chk("rst_state", 64'(bus.State), 64'(S_FETCH));
      chk("rst_count", 64'(bus.InstrCount), 64'd0);
      chk("rst_timeout", 64'(bus.MemTimeout), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      bus.MemReady = 1'b1;

`ifdef ILLEGAL_TRAP_EN
      bus.OP = 6'h3f;
      wait_state(S_TRAP, "to_trap");
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         if (bus.State !== S_TRAP || bus.IllegalOp !== 1'b1 ||
             {bus.PCWrite, bus.PCWriteCond, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite} !== 6'd0)
            bad++;
         @(negedge clk);
      end
      chk("trap_bad_cycles", 64'(bad), 64'd0);
      chk("trap_count", 64'(bus.InstrCount), 64'd0);
`else
      bus.OP = 6'h3f;
      bad = 0;
      run_instr(6'h3f, 1'b0, 0, n, lst, lctl, c3);
      chk("nop_after_reset_count", 64'(bus.InstrCount), 64'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
